// File: rtl/control_fsm_if.sv
// control_fsm_if -- signal bundle between the multicycle main controller and its datapath.
//
// Signals
//   op        [6:0]  instruction opcode, Instr[6:0]
//   zero             ALU zero flag
//   mem_ready        memory access completes this cycle
//   PCWrite          load PC
//   AdrSrc           memory address select (0 = PC, 1 = ALU result)
//   MemWrite         memory write strobe
//   IRWrite          load instruction register
//   RegWrite         register file write enable
//   ResultSrc [1:0]  result mux select
//   ALUSrcA   [1:0]  ALU operand A select (11 = constant zero, U-type only)
//   ALUSrcB   [1:0]  ALU operand B select
//   ALUOp     [1:0]  ALU decoder class
//   ImmSrc    [2:0]  immediate extender select: 000 I, 001 S, 010 B, 011 U, 100 J
//   state     [3:0]  current controller state (debug)
//
// Modports
//   master  controller side: consumes op/zero/mem_ready, drives the control lines
//   slave   datapath side: drives op/zero/mem_ready, consumes the control lines

interface control_fsm_if;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [2:0] ImmSrc;
    logic [3:0] state;

    modport master (
        input  op, zero, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
        output ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, state
    );

    modport slave (
        output op, zero, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
        input  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, state
    );
endinterface

// File: rtl/control_fsm.sv
// control_fsm -- multicycle RISC-V main controller.
//
// Moore FSM with a registered 4-bit state. Control lines are decoded combinationally from the
// state plus op, zero and mem_ready. Only FETCH, MEMREAD and MEMWRITE wait on mem_ready, and
// those waits have no timeout.
//
// Ports
//   clk   in   single clock, rising edge
//   rst   in   synchronous, active-high reset (returns to FETCH from any state)
//   bus   control_fsm_if.master: op/zero/mem_ready in, control lines and debug state out
//
// Configuration
//   UTYPE_EN  when defined, adds LUI (state 11) and AUIPC (state 12) handling and the U-type
//             immediate select. When undefined, both opcodes fall back from DECODE to FETCH.

module control_fsm (
    input logic           clk,
    input logic           rst,
    control_fsm_if.master bus
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StAluWb    = 4'd7,
        StExecI    = 4'd8,
        StJal      = 4'd9,
        StBeq      = 4'd10,
        StLui      = 4'd11,
        StAuipc    = 4'd12
    } state_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRtype  = 7'b0110011;
    localparam logic [6:0] OpItype  = 7'b0010011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpBranch = 7'b1100011;
`ifdef UTYPE_EN
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
`endif

    state_e state_q, state_d;
    state_e state_cur;

    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [2:0] imm_src;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and control lines. While rst is high the decoder behaves as if in FETCH so
    // no write strobe from a stalled MEMWRITE can leak through during the reset cycle.
    always_comb begin
        state_d    = StFetch;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        state_cur  = rst ? StFetch : state_q;

        case (state_cur)
            StFetch: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                // Instruction fetch completes only on a real ready beat outside reset.
                ir_write   = bus.mem_ready & ~rst;
                pc_write   = bus.mem_ready & ~rst;
                state_d    = bus.mem_ready ? StDecode : StFetch;
            end

            StDecode: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (bus.op)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRtype:         state_d = StExecR;
                    OpItype:         state_d = StExecI;
                    OpJal:           state_d = StJal;
                    OpBranch:        state_d = StBeq;
`ifdef UTYPE_EN
                    OpLui:           state_d = StLui;
                    OpAuipc:         state_d = StAuipc;
`endif
                    default:         state_d = StFetch;
                endcase
            end

            StMemAdr: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (bus.op == OpLoad) ? StMemRead : StMemWrite;
            end

            StMemRead: begin
                adr_src = 1'b1;
                state_d = bus.mem_ready ? StMemWb : StMemRead;
            end

            StMemWb: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = StFetch;
            end

            StMemWrite: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                state_d   = bus.mem_ready ? StFetch : StMemWrite;
            end

            StExecR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = StAluWb;
            end

            StExecI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = StAluWb;
            end

            StAluWb: begin
                reg_write = 1'b1;
                state_d   = StFetch;
            end

            StJal: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_d   = StAluWb;
            end

            StBeq: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pc_write  = bus.zero;
                state_d   = StFetch;
            end

`ifdef UTYPE_EN
            StLui: begin
                // Operand A forced to zero so the ALU passes the U immediate straight through.
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
                state_d   = StAluWb;
            end

            StAuipc: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                state_d   = StAluWb;
            end
`endif

            // Unused codes (and LUI/AUIPC when not compiled in): all outputs low, recover.
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    // Immediate select depends only on the opcode, independent of state.
    always_comb begin
        imm_src = 3'b000;
        case (bus.op)
            OpStore:  imm_src = 3'b001;
            OpBranch: imm_src = 3'b010;
            OpJal:    imm_src = 3'b100;
`ifdef UTYPE_EN
            OpLui, OpAuipc: imm_src = 3'b011;
`endif
            default:  imm_src = 3'b000;
        endcase
    end

    assign bus.PCWrite   = pc_write;
    assign bus.AdrSrc    = adr_src;
    assign bus.MemWrite  = mem_write;
    assign bus.IRWrite   = ir_write;
    assign bus.RegWrite  = reg_write;
    assign bus.ResultSrc = result_src;
    assign bus.ALUSrcA   = alu_src_a;
    assign bus.ALUSrcB   = alu_src_b;
    assign bus.ALUOp     = alu_op;
    assign bus.ImmSrc    = imm_src;
    assign bus.state     = state_q;

`ifndef SYNTHESIS
    // A write strobe may only come from the MEMWRITE state.
    a_mem_write_state : assert property (@(posedge clk) disable iff (rst)
        mem_write |-> (state_q == StMemWrite));

    // The register file never writes during fetch.
    a_no_fetch_regwrite : assert property (@(posedge clk) disable iff (rst)
        (state_q == StFetch) |-> !reg_write);

`ifndef UTYPE_EN
    // Without U-type support the zero operand select is never used.
    a_no_zero_operand : assert property (@(posedge clk) alu_src_a != 2'b11);
`endif
`endif

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, rising edge; rst  in  1  synchronous, active-high reset.
REQ-002 SHALL have ports: op  in  7  Instr[6:0]; zero  in  1  ALU zero flag; mem_ready  in  1  memory access complete this cycle.
REQ-003 SHALL have outputs: PCWrite 1, AdrSrc 1, MemWrite 1, IRWrite 1, RegWrite 1, ResultSrc 2, ALUSrcA 2, ALUSrcB 2, ALUOp 2, ImmSrc 3, state 4 (debug).
REQ-004 ImmSrc SHALL drive the immediate extender select: 000 I, 001 S, 010 B, 011 U, 100 J.

Function
REQ-005 SHALL be a multicycle RISC-V main controller: Moore FSM, registered 4-bit state, outputs decoded combinationally from state, op, zero and mem_ready.
REQ-006 State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10, LUI=11, AUIPC=12; 13-15 unused.
REQ-007 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; hold while mem_ready=0; when mem_ready=1, IRWrite=1 and PCWrite=1 for that cycle only, then DECODE.
REQ-008 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00; next by op: 0000011/0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1101111 -> JAL, 1100011 -> BEQ; any other op -> FETCH.
REQ-009 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; op=0000011 -> MEMREAD, else MEMWRITE.
REQ-010 MEMREAD: AdrSrc=1, ResultSrc=00; hold until mem_ready=1, then MEMWB.
REQ-011 MEMWB: ResultSrc=01, RegWrite=1; -> FETCH.
REQ-012 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 every cycle in state; hold until mem_ready=1, then FETCH.
REQ-013 EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB; EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
REQ-014 ALUWB: ResultSrc=00, RegWrite=1; -> FETCH.
REQ-015 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1; -> ALUWB.
REQ-016 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=zero; -> FETCH.
REQ-017 Any output not listed for a state SHALL be 0; unused state codes SHALL drive all-zero outputs and go to FETCH next cycle.
REQ-018 ImmSrc SHALL be decoded from op in every state: 0100011 -> 001, 1100011 -> 010, 1101111 -> 100, 0110111/0010111 -> 011 (macro only), else 000.
REQ-019 Only FETCH, MEMREAD and MEMWRITE SHALL stall; stalls have no timeout.

Reset
REQ-020 rst=1 at a rising edge SHALL set state=FETCH, from any state including mid-stall.
REQ-021 During and after reset, outputs SHALL be FETCH outputs; IRWrite/PCWrite SHALL assert only if mem_ready=1 in a cycle with rst=0.
REQ-022 MemWrite SHALL be 0 from the first cycle after a reset edge, even if reset occurred in MEMWRITE.

Configuration
REQ-023 Macro UTYPE_EN SHALL compile in LUI/AUIPC support.
REQ-024 With UTYPE_EN: DECODE op 0110111 -> LUI (ALUSrcA=11 zero operand, ALUSrcB=01, ALUOp=00), op 0010111 -> AUIPC (ALUSrcA=01, ALUSrcB=01, ALUOp=00); both -> ALUWB; ImmSrc=011 for both ops.
REQ-025 Without UTYPE_EN: states 11/12 unreachable, both ops take DECODE -> FETCH, ImmSrc=000; ALUSrcA never 11.

Verification
REQ-026 lw (op=0000011), mem_ready=1 always -> states 0,1,2,3,4,0; RegWrite=1 only in MEMWB, ResultSrc=01.
REQ-027 sw (op=0100011), mem_ready low 3 cycles in MEMWRITE -> MemWrite=1 for 4 cycles, ImmSrc=001 throughout, then FETCH.
REQ-028 beq (op=1100011): zero=1 -> PCWrite=1 in BEQ, ImmSrc=010; zero=0 -> PCWrite=0; both return to FETCH after 3 cycles.
REQ-029 jal (op=1101111) -> states 0,1,9,7,0; PCWrite=1 in JAL, RegWrite=1 in ALUWB, ImmSrc=100.
REQ-030 op=0110111: UTYPE_EN -> states 0,1,11,7,0, ALUSrcA=11 in LUI, ImmSrc=011; without macro -> 0,1,0.
REQ-031 rst=1 while stalled in MEMREAD or MEMWRITE -> state=0 next cycle, MemWrite=0, RegWrite=0; op=1111111 -> DECODE then FETCH.
